// File: rtl/animated_sprite_if.sv
// ============================================================================
// Module   : animated_sprite_if
// Brief    : Beam/sprite position inputs and sprite-local coordinate outputs
//            for the per-pixel sprite window decoder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface animated_sprite_if #(
  parameter int CW = 4
);
  logic [9:0]    shpos;
  logic [9:0]    svpos;
  logic [9:0]    xpos;
  logic [9:0]    ypos;
  logic [CW-1:0] xout;
  logic [CW-1:0] yout;
  logic          active;

  // master: video timing side driving positions and consuming coordinates
  modport master (
    output shpos, svpos, xpos, ypos,
    input  xout, yout, active
  );

  modport slave (
    input  shpos, svpos, xpos, ypos,
    output xout, yout, active
  );
endinterface

`default_nettype wire

// File: rtl/animated_sprite.sv
// ============================================================================
// Module   : animated_sprite
// Brief    : Per-pixel sprite window decoder producing registered sprite-local
//            column/row, forced to (0,0) outside the window.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module animated_sprite #(
  parameter int SPR_W = 16,
  parameter int SPR_H = 16,
  parameter int CW    = 4
) (
  input  wire logic          clk,
  input  wire logic          reset,
  animated_sprite_if.slave   spr
);

  logic [9:0]    dx;
  logic [9:0]    dy;
  logic          in_x;
  logic          in_y;
  logic          hit;

  logic [CW-1:0] xout_d;
  logic [CW-1:0] xout_q;
  logic [CW-1:0] yout_d;
  logic [CW-1:0] yout_q;
  logic          active_d;
  logic          active_q;

  // Modulo-1024 subtraction lets a sprite straddle the screen-coordinate wrap.
  always_comb begin
    dx   = spr.shpos - spr.xpos;
    dy   = spr.svpos - spr.ypos;
    in_x = ({1'b0, dx} < 11'(SPR_W));
    in_y = ({1'b0, dy} < 11'(SPR_H));
    hit  = in_x & in_y;
  end

  // Texel (0,0) is transparent, so zero coordinates double as the outside mask.
  always_comb begin
    xout_d   = '0;
    yout_d   = '0;
    active_d = 1'b0;
    if (hit) begin
      xout_d   = dx[CW-1:0];
      yout_d   = dy[CW-1:0];
      active_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      xout_q   <= '0;
      yout_q   <= '0;
      active_q <= 1'b0;
    end else begin
      xout_q   <= xout_d;
      yout_q   <= yout_d;
      active_q <= active_d;
    end
  end

  assign spr.xout   = xout_q;
  assign spr.yout   = yout_q;
  assign spr.active = active_q;

endmodule

`default_nettype wire

// File: tb/tb_animated_sprite.sv
// ============================================================================
// Module   : tb_animated_sprite
// Brief    : Scoreboard bench for animated_sprite with directed vectors.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_animated_sprite;

  typedef struct {
    logic [3:0] x;
    logic [3:0] y;
    logic       a;
    string      name;
  } exp_t;

  logic clk;
  logic reset;
  exp_t exp_q[$];
  int   checks;
  int   failures;
  bit   stim_done;

  animated_sprite_if #(.CW(4)) sif ();

  animated_sprite #(
    .SPR_W (16),
    .SPR_H (16),
    .CW    (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .spr   (sif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs and queue the response expected after the next edge.
  task automatic drive(input logic r, input int xp, input int yp, input int sh, input int sv,
                       input int ex, input int ey, input int ea, input string name);
    exp_t e;
    @(negedge clk);
    reset     = r;
    sif.xpos  = 10'(xp);
    sif.ypos  = 10'(yp);
    sif.shpos = 10'(sh);
    sif.svpos = 10'(sv);
    e.x    = 4'(ex);
    e.y    = 4'(ey);
    e.a    = ea[0];
    e.name = name;
    exp_q.push_back(e);
  endtask

  // Monitor: outputs are valid every cycle; compare one queued entry per edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (sif.xout !== e.x || sif.yout !== e.y || sif.active !== e.a) begin
          failures++;
          $display("FAIL %s: got xout=%0d yout=%0d active=%0d, expected xout=%0d yout=%0d active=%0d",
                   e.name, sif.xout, sif.yout, sif.active, e.x, e.y, e.a);
        end
      end
    end
  end

  initial begin
    checks    = 0;
    failures  = 0;
    stim_done = 1'b0;
    reset     = 1'b1;
    sif.xpos  = '0;
    sif.ypos  = '0;
    sif.shpos = '0;
    sif.svpos = '0;

    drive(1, 0, 0, 0, 0, 0, 0, 0, "reset0");
    drive(1, 0, 0, 0, 0, 0, 0, 0, "reset1");
    drive(0, 0, 0, 0, 0, 0, 0, 1, "origin_hit");
    drive(0, 100, 50, 103, 57, 3, 7, 1, "inside_basic");
    drive(0, 100, 50, 115, 65, 15, 15, 1, "corner_max");
    drive(0, 100, 50, 116, 65, 0, 0, 0, "x_edge_out");
    drive(0, 100, 50, 115, 66, 0, 0, 0, "y_edge_out");
    drive(0, 100, 50, 100, 50, 0, 0, 1, "top_left");
    drive(0, 1020, 1020, 2, 0, 6, 4, 1, "wrap_inside");
    drive(0, 1020, 1020, 1023, 1021, 3, 1, 1, "wrap_pre");
    drive(0, 1020, 1020, 12, 0, 0, 0, 0, "wrap_x_out");
    drive(0, 100, 50, 99, 55, 0, 0, 0, "left_out");
    drive(0, 200, 300, 210, 301, 10, 1, 1, "pos_change");
    drive(0, 100, 50, 105, 49, 0, 0, 0, "above_out");

    for (int sh = 96; sh <= 120; sh++) begin
      if (sh == 108)
        drive(1, 100, 50, sh, 52, 0, 0, 0, "sweep_reset");
      else if (sh >= 100 && sh <= 115)
        drive(0, 100, 50, sh, 52, sh - 100, 2, 1, "sweep_in");
      else
        drive(0, 100, 50, sh, 52, 0, 0, 0, "sweep_out");
    end
    stim_done = 1'b1;

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain: %0d responses outstanding, expected 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, expected completion");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
